gpu_noc_ni: RTL and testbench

Parametrised GPU network interface, the successor to the fixed 32-GPU, 16-bit NI. Sits between one GPU and its leaf router port: translates GPU destination IDs into Group/Leaf routing headers on egress and back into GPU IDs on ingress. Buffers each direction in its own FIFO with full valid/ready handshakes on all four interfaces. Drops and counts illegal or misdelivered packets.

---
 rtl/gpu_noc_pkg.sv | 29 ++
 rtl/gpu_noc_ni_if.sv | 11 +
 rtl/ni_sync_fifo.sv | 53 +++++
 rtl/gpu_noc_ni.sv | 143 ++++++++++++++
 tb/tb_gpu_noc_ni.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_noc_pkg.sv
// Shared constants and header helpers for the GPU network interface.
package gpu_noc_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ID_W       = 6;
  localparam int DEF_ADDR_BASE  = 4;
  localparam int DEF_NUM_GPUS   = 32;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_CNT_W      = 16;

  // GPU 1 sits at routing address addr_base; the rest follow contiguously.
  function automatic int id_to_addr(input int id, input int addr_base);
    return id + addr_base - 1;
  endfunction

  function automatic int addr_to_id(input int addr, input int addr_base);
    return addr - addr_base + 1;
  endfunction

  function automatic bit id_legal(input int id, input int num_gpus);
    return (id >= 1) && (id <= num_gpus);
  endfunction

  // Lowest bit of the header field; everything below it is payload.
  function automatic int hdr_lsb(input int data_w, input int id_w);
    return data_w - id_w;
  endfunction

endpackage

// File: rtl/gpu_noc_ni_if.sv
// Single valid/ready flit stream; master drives data/valid, slave drives ready.
interface gpu_noc_ni_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ni_sync_fifo.sv
// Synchronous FIFO with occupancy count; head is the oldest entry (valid when !empty_o).
module ni_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        din_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [DATA_W-1:0]        head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is left unreset; contents are only observed through the count.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/gpu_noc_ni.sv
// GPU network interface: ID<->address translation, per-direction FIFO and
// registered output stage, drop counters for illegal or misdelivered flits.
module gpu_noc_ni
  import gpu_noc_pkg::*;
#(
  parameter int GPU_ID     = 1,
  parameter int NUM_GPUS   = DEF_NUM_GPUS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ID_W       = DEF_ID_W,
  parameter int ADDR_BASE  = DEF_ADDR_BASE,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  gpu_noc_ni_if.slave                   gpu_in,
  gpu_noc_ni_if.master                  router_out,
  gpu_noc_ni_if.slave                   router_in,
  gpu_noc_ni_if.master                  gpu_out,
  output logic [CNT_W-1:0]              tx_drop_cnt,
  output logic [CNT_W-1:0]              rx_drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

  localparam int HDR_LSB = hdr_lsb(DATA_W, ID_W);
  localparam logic [ID_W-1:0] OWN_ADDR = ID_W'(id_to_addr(GPU_ID, ADDR_BASE));
  localparam logic [ID_W-1:0] OWN_ID   = ID_W'(addr_to_id(int'(OWN_ADDR), ADDR_BASE));

  // ---------------- egress: GPU -> router ----------------
  logic [ID_W-1:0]    tx_dest;
  logic [ID_W-1:0]    tx_addr;
  logic [HDR_LSB-1:0] tx_payload;
  logic               tx_legal;
  logic               tx_accept, tx_push, tx_drop, tx_pop;
  logic               tx_full, tx_empty;
  logic [DATA_W-1:0]  tx_head;
  logic [DATA_W-1:0]  rtr_data_q;
  logic               rtr_valid_q;
  logic [CNT_W-1:0]   tx_drop_q;

  assign tx_dest    = gpu_in.data[DATA_W-1 -: ID_W];
  assign tx_payload = gpu_in.data[HDR_LSB-1:0];
  assign tx_legal   = id_legal(int'(tx_dest), NUM_GPUS);
  assign tx_addr    = ID_W'(id_to_addr(int'(tx_dest), ADDR_BASE));

  // Ready depends only on the registered occupancy.
  assign gpu_in.ready = ~tx_full;
  assign tx_accept    = gpu_in.valid & gpu_in.ready;
  assign tx_push      = tx_accept & tx_legal;
  assign tx_drop      = tx_accept & ~tx_legal;
  assign tx_pop       = ~tx_empty & (~rtr_valid_q | router_out.ready);

  ni_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tx_push),
    .din_i   ({tx_addr, tx_payload}),
    .pop_i   (tx_pop),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_level),
    .head_o  (tx_head)
  );

  // Router-side output register: reload from the FIFO or retire when accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rtr_valid_q <= 1'b0;
      rtr_data_q  <= '0;
    end else if (tx_pop) begin
      rtr_valid_q <= 1'b1;
      rtr_data_q  <= tx_head;
    end else if (router_out.ready) begin
      rtr_valid_q <= 1'b0;
    end
  end

  // Saturating count of flits with an out-of-range destination.
  always_ff @(posedge clk) begin
    if (reset)                          tx_drop_q <= '0;
    else if (tx_drop && tx_drop_q != '1) tx_drop_q <= tx_drop_q + 1'b1;
  end

  assign router_out.valid = rtr_valid_q;
  assign router_out.data  = rtr_data_q;
  assign tx_drop_cnt      = tx_drop_q;

  // ---------------- ingress: router -> GPU ----------------
  logic [ID_W-1:0]    rx_hdr;
  logic [HDR_LSB-1:0] rx_payload;
  logic               rx_accept, rx_push, rx_drop, rx_pop;
  logic               rx_full, rx_empty;
  logic [DATA_W-1:0]  rx_head;
  logic [DATA_W-1:0]  gpu_data_q;
  logic               gpu_valid_q;
  logic [CNT_W-1:0]   rx_drop_q;

  assign rx_hdr     = router_in.data[DATA_W-1 -: ID_W];
  assign rx_payload = router_in.data[HDR_LSB-1:0];

  assign router_in.ready = ~rx_full;
  assign rx_accept       = router_in.valid & router_in.ready;
  assign rx_push         = rx_accept & (rx_hdr == OWN_ADDR);
  assign rx_drop         = rx_accept & (rx_hdr != OWN_ADDR);
  assign rx_pop          = ~rx_empty & (~gpu_valid_q | gpu_out.ready);

  ni_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_push),
    .din_i   ({OWN_ID, rx_payload}),
    .pop_i   (rx_pop),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_level),
    .head_o  (rx_head)
  );

  // GPU-side output register: reload from the FIFO or retire when accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      gpu_valid_q <= 1'b0;
      gpu_data_q  <= '0;
    end else if (rx_pop) begin
      gpu_valid_q <= 1'b1;
      gpu_data_q  <= rx_head;
    end else if (gpu_out.ready) begin
      gpu_valid_q <= 1'b0;
    end
  end

  // Saturating count of flits whose address is not this node.
  always_ff @(posedge clk) begin
    if (reset)                          rx_drop_q <= '0;
    else if (rx_drop && rx_drop_q != '1) rx_drop_q <= rx_drop_q + 1'b1;
  end

  assign gpu_out.valid = gpu_valid_q;
  assign gpu_out.data  = gpu_data_q;
  assign rx_drop_cnt   = rx_drop_q;

endmodule

// File: tb/tb_gpu_noc_ni.sv
// Bench for gpu_noc_ni with GPU_ID=31: directed stimulus, queue-based model,
// per-cycle compare process, and literal checks that pin the model.
module tb_gpu_noc_ni;

  localparam int DW    = 16;
  localparam int IDW   = 6;
  localparam int GID   = 31;
  localparam int NG    = 32;
  localparam int AB    = 4;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int PL    = 1 << (DW - IDW);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gpu_noc_ni_if #(.DATA_W(DW)) gpu_in ();
  gpu_noc_ni_if #(.DATA_W(DW)) router_out ();
  gpu_noc_ni_if #(.DATA_W(DW)) router_in ();
  gpu_noc_ni_if #(.DATA_W(DW)) gpu_out ();

  logic [CW-1:0] tx_drop_cnt, rx_drop_cnt;
  logic [3:0]    tx_level, rx_level;

  gpu_noc_ni #(
    .GPU_ID(GID), .NUM_GPUS(NG), .DATA_W(DW), .ID_W(IDW),
    .ADDR_BASE(AB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .gpu_in      (gpu_in),
    .router_out  (router_out),
    .router_in   (router_in),
    .gpu_out     (gpu_out),
    .tx_drop_cnt (tx_drop_cnt),
    .rx_drop_cnt (rx_drop_cnt),
    .tx_level    (tx_level),
    .rx_level    (rx_level)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];
  int  tx_drops = 0;
  int  rx_drops = 0;
  bit  after_reset = 1'b0;
  bit  tx_stall = 1'b0;
  bit  rx_stall = 1'b0;

  // Outputs are stable at the falling edge; check them, then fold in the
  // handshakes that the next rising edge will complete.
  always @(negedge clk) begin
    int lvl;
    int d;
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      tx_drops = 0;
      rx_drops = 0;
      tx_stall = 1'b0;
      rx_stall = 1'b0;
      after_reset = 1'b1;
    end else begin
      if (after_reset) begin
        chk("rst_rtr_valid", 32'(router_out.valid), 32'd0);
        chk("rst_gpu_valid", 32'(gpu_out.valid), 32'd0);
        chk("rst_rtr_data", 32'(router_out.data), 32'd0);
        chk("rst_gpu_data", 32'(gpu_out.data), 32'd0);
      end
      after_reset = 1'b0;

      lvl = tx_q.size() - int'(router_out.valid);
      chk("tx_level", 32'(tx_level), 32'(lvl));
      chk("gpu_ready", 32'(gpu_in.ready), (lvl < DEPTH) ? 32'd1 : 32'd0);
      lvl = rx_q.size() - int'(gpu_out.valid);
      chk("rx_level", 32'(rx_level), 32'(lvl));
      chk("router_ready", 32'(router_in.ready), (lvl < DEPTH) ? 32'd1 : 32'd0);
      chk("tx_drop_cnt", 32'(tx_drop_cnt), 32'(tx_drops));
      chk("rx_drop_cnt", 32'(rx_drop_cnt), 32'(rx_drops));

      if (tx_stall) chk("tx_hold_valid", 32'(router_out.valid), 32'd1);
      if (rx_stall) chk("rx_hold_valid", 32'(gpu_out.valid), 32'd1);
      if (router_out.valid) begin
        if (tx_q.size() == 0) chk("tx_spurious", 32'(router_out.data), 32'hFFFF_FFFF);
        else                  chk("tx_data", 32'(router_out.data), 32'(tx_q[0]));
      end
      if (gpu_out.valid) begin
        if (rx_q.size() == 0) chk("rx_spurious", 32'(gpu_out.data), 32'hFFFF_FFFF);
        else                  chk("rx_data", 32'(gpu_out.data), 32'(rx_q[0]));
      end

      tx_stall = router_out.valid && !router_out.ready;
      rx_stall = gpu_out.valid && !gpu_out.ready;
      if (router_out.valid && router_out.ready && tx_q.size() > 0) void'(tx_q.pop_front());
      if (gpu_out.valid && gpu_out.ready && rx_q.size() > 0) void'(rx_q.pop_front());

      if (gpu_in.valid && gpu_in.ready) begin
        d = int'(gpu_in.data);
        if (d / PL >= 1 && d / PL <= NG) tx_q.push_back(DW'((d / PL + AB - 1) * PL + d % PL));
        else tx_drops++;
      end
      if (router_in.valid && router_in.ready) begin
        d = int'(router_in.data);
        if (d / PL == GID + AB - 1) rx_q.push_back(DW'(GID * PL + d % PL));
        else rx_drops++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tx(input logic [DW-1:0] d);
    int n = 0;
    gpu_in.valid = 1'b1;
    gpu_in.data  = d;
    while (!gpu_in.ready && n < 50) begin step(); n++; end
    if (n >= 50) chk("tx_ready_timeout", 32'(n), 32'd0);
    step();
  endtask

  task automatic send_rx(input logic [DW-1:0] d);
    int n = 0;
    router_in.valid = 1'b1;
    router_in.data  = d;
    while (!router_in.ready && n < 50) begin step(); n++; end
    if (n >= 50) chk("rx_ready_timeout", 32'(n), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    gpu_in.valid = 1'b0;     gpu_in.data = '0;
    router_in.valid = 1'b0;  router_in.data = '0;
    router_out.ready = 1'b1; gpu_out.ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_gpu_ready", 32'(gpu_in.ready), 32'd1);
    chk("reset_router_ready", 32'(router_in.ready), 32'd1);
    chk("reset_tx_level", 32'(tx_level), 32'd0);

    // Egress latency: dest 31 -> addr 34, exactly one valid cycle.
    send_tx(16'h7C05);
    gpu_in.valid = 1'b0;
    chk("lat_not_yet", 32'(router_out.valid), 32'd0);
    step();
    chk("lat_valid", 32'(router_out.valid), 32'd1);
    chk("lat_data", 32'(router_out.data), 32'h8805);
    step();
    chk("lat_one_cycle", 32'(router_out.valid), 32'd0);

    // Illegal destinations 0 and 33.
    send_tx(16'h0005);
    send_tx(16'h8405);
    gpu_in.valid = 1'b0;
    repeat (3) step();
    chk("tx_drop_two", 32'(tx_drop_cnt), 32'd2);
    chk("drop_ready_high", 32'(gpu_in.ready), 32'd1);

    // Ingress: own address restored to GPU 31, foreign address dropped.
    send_rx(16'h8801);
    router_in.valid = 1'b0;
    step();
    chk("rx_valid", 32'(gpu_out.valid), 32'd1);
    chk("rx_xlate", 32'(gpu_out.data), 32'h7C01);
    send_rx(16'h8401);
    router_in.valid = 1'b0;
    repeat (3) step();
    chk("rx_drop_one", 32'(rx_drop_cnt), 32'd1);

    // Backpressure: 9 flits fill output register plus 8 FIFO entries.
    router_out.ready = 1'b0;
    for (int i = 0; i < 9; i++) send_tx(DW'(16'h1400 + i));
    gpu_in.valid = 1'b0;
    chk("bp_level_full", 32'(tx_level), 32'd8);
    chk("bp_ready_low", 32'(gpu_in.ready), 32'd0);
    repeat (3) step();
    router_out.ready = 1'b1;
    repeat (12) step();
    chk("bp_drained", 32'(tx_level), 32'd0);
    chk("bp_all_delivered", 32'(tx_q.size()), 32'd0);

    // Steady state at level 4 with simultaneous push and pop.
    router_out.ready = 1'b0;
    gpu_out.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      gpu_in.valid = 1'b1;    gpu_in.data = DW'(16'h1800 + i);
      router_in.valid = 1'b1; router_in.data = DW'(16'h8810 + i);
      step();
    end
    chk("pp_tx_level4", 32'(tx_level), 32'd4);
    chk("pp_rx_level4", 32'(rx_level), 32'd4);
    router_out.ready = 1'b1;
    gpu_out.ready = 1'b1;
    for (int i = 5; i < 25; i++) begin
      gpu_in.data = DW'(16'h1800 + i);
      router_in.data = DW'(16'h8810 + i);
      step();
      chk("pp_tx_hold4", 32'(tx_level), 32'd4);
      chk("pp_rx_hold4", 32'(rx_level), 32'd4);
    end
    gpu_in.valid = 1'b0;
    router_in.valid = 1'b0;
    repeat (10) step();
    chk("pp_tx_empty", 32'(tx_q.size()), 32'd0);
    chk("pp_rx_empty", 32'(rx_q.size()), 32'd0);

    // Reset while both directions are half full and presenting data.
    router_out.ready = 1'b0;
    gpu_out.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      gpu_in.valid = 1'b1;    gpu_in.data = DW'(16'h2000 + i);
      router_in.valid = 1'b1; router_in.data = DW'(16'h8820 + i);
      step();
    end
    gpu_in.valid = 1'b0;
    router_in.valid = 1'b0;
    chk("pre_rst_tx_valid", 32'(router_out.valid), 32'd1);
    chk("pre_rst_rx_valid", 32'(gpu_out.valid), 32'd1);
    chk("pre_rst_tx_drop", 32'(tx_drop_cnt), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_tx_valid", 32'(router_out.valid), 32'd0);
    chk("mrst_rx_valid", 32'(gpu_out.valid), 32'd0);
    chk("mrst_tx_level", 32'(tx_level), 32'd0);
    chk("mrst_rx_level", 32'(rx_level), 32'd0);
    chk("mrst_tx_drop", 32'(tx_drop_cnt), 32'd0);
    chk("mrst_rx_drop", 32'(rx_drop_cnt), 32'd0);
    chk("mrst_gpu_ready", 32'(gpu_in.ready), 32'd1);
    chk("mrst_router_ready", 32'(router_in.ready), 32'd1);

    // Traffic resumes after reset; dest == own ID still goes to the router.
    router_out.ready = 1'b1;
    gpu_out.ready = 1'b1;
    send_tx(16'h7C3F);
    gpu_in.valid = 1'b0;
    step();
    chk("post_rst_data", 32'(router_out.data), 32'h883F);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
